// File: rtl/div_display_pkg.sv
// Shared definitions for the divider result display: glyph codes, FSM
// states, the divider's divide-by-zero marker and the digit-to-glyph mapping.
package div_display_pkg;

  // {cociente,resto} value the divider emits on divide-by-zero
  localparam logic [7:0] DIV_ERR_CODE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Glyph codes: 0..9 are the decimal digits themselves
  typedef logic [3:0] glyph_t;
  localparam glyph_t GLYPH_E     = 4'd10;
  localparam glyph_t GLYPH_R     = 4'd11;
  localparam glyph_t GLYPH_BLANK = 4'd15;

  // Units digit of a 4-bit value (0..15)
  function automatic glyph_t units_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  // Tens digit of a 4-bit value; a leading zero is blanked
  function automatic glyph_t tens_of(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : GLYPH_BLANK;
  endfunction

  // Glyph shown on digit idx (3 = leftmost) for the given state and data
  function automatic glyph_t pick_glyph(input state_t st, input logic [1:0] idx,
                                        input logic [3:0] q, input logic [3:0] r);
    glyph_t g;
    g = GLYPH_BLANK;
    if (st == ST_ERR) begin
      case (idx)
        2'd3:    g = GLYPH_E;
        2'd2:    g = GLYPH_R;
        2'd1:    g = GLYPH_R;
        default: g = GLYPH_BLANK;
      endcase
    end else if (st == ST_SHOW) begin
      case (idx)
        2'd3:    g = tens_of(q);
        2'd2:    g = units_of(q);
        2'd1:    g = tens_of(r);
        default: g = units_of(r);
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/div_display_if.sv
// Result bus from the divider: one-cycle finish pulse with quotient/remainder.
interface div_display_if;
  logic       finish;
  logic [3:0] cociente;
  logic [3:0] resto;

  modport master (output finish, cociente, resto);
  modport slave  (input  finish, cociente, resto);
endinterface

// File: rtl/div_display_seg7_decoder.sv
// Glyph code to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder
  import div_display_pkg::*;
(
  input  glyph_t     i_glyph,
  output logic [6:0] o_seg
);

  // Pure lookup; any unused code lights nothing
  always_comb begin
    o_seg = 7'b1111111;
    case (i_glyph)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      GLYPH_E: o_seg = 7'b0000110;
      GLYPH_R: o_seg = 7'b0101111;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/div_display.sv
// Captures the divider result on its finish pulse and scans it onto a
// 4-digit common-anode display: quotient on digits 3..2, remainder on 1..0,
// "Err" for the divide-by-zero marker.
module div_display
  import div_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  div_display_if.slave       i_res,
  output logic [6:0]         o_seg,
  output logic [3:0]         o_an,
  output logic               o_valid,
  output logic               o_err
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_q, r_r;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          w_tc;
  glyph_t        w_glyph;
  logic [6:0]    w_seg;

  assign w_tc = (r_cnt == CW'(REFRESH_DIV - 1));

  // Next state: every finish picks SHOW or ERR; only reset returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (i_res.finish)
      w_state_nxt = ({i_res.cociente, i_res.resto} == DIV_ERR_CODE) ? ST_ERR : ST_SHOW;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Result capture; each finish overwrites the previous result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      r_r <= '0;
    end else if (i_res.finish) begin
      r_q <= i_res.cociente;
      r_r <= i_res.resto;
    end
  end

  // Free-running refresh timer; capture never disturbs the scan phase
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_glyph = pick_glyph(r_state, r_idx, r_q, r_r);

  seg7_decoder u_dec (
    .i_glyph (w_glyph),
    .o_seg   (w_seg)
  );

  // Registered drivers; display stays dark until a result exists
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == ST_IDLE) begin
      o_an  <= 4'b1111;
      o_seg <= 7'b1111111;
    end else begin
      o_an  <= ~(4'b0001 << r_idx);
      o_seg <= w_seg;
    end
  end

  assign o_valid = (r_state != ST_IDLE);
  assign o_err   = (r_state == ST_ERR);

endmodule

// File: tb/tb_div_display.sv
// Bench for div_display with REFRESH_DIV=4: a per-cycle arithmetic model of
// the scan, a table of result/glyph vectors, hand-written corner sequences
// and a randomized run.
module tb_div_display;

  localparam int R = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SE = 7'b0000110, SR = 7'b0101111,
                         SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] an;
  logic       valid, err;

  always #5 clk = ~clk;

  div_display_if bus ();

  div_display #(.REFRESH_DIV(R)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_res   (bus),
    .o_seg   (seg),
    .o_an    (an),
    .o_valid (valid),
    .o_err   (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: edges since reset, latched data, flags
  int k;
  int mq, mr;
  bit mvalid, merr;

  typedef struct {
    int               q;
    int               r;
    logic [3:0][6:0]  d;   // d[3] = leftmost digit
    bit               e;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dig7(input int d);
    case (d)
      0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
      5: return S5; 6: return S6; 7: return S7; 8: return S8; 9: return S9;
      default: return SB;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int idx);
    int v;
    if (!mvalid) return SB;
    if (merr) begin
      if (idx == 3) return SE;
      if (idx == 0) return SB;
      return SR;
    end
    v = (idx >= 2) ? mq : mr;
    if (idx % 2 == 1) return (v >= 10) ? dig7(v / 10) : SB;
    return dig7(v % 10);
  endfunction

  // One clock: drive inputs, advance the model, compare all outputs
  task automatic step(input bit r_i, input bit f, input int q, input int rr);
    int         idx;
    logic [3:0] ea;
    logic [6:0] es;
    @(negedge clk);
    rst          = r_i;
    bus.finish   = f;
    bus.cociente = q[3:0];
    bus.resto    = rr[3:0];
    @(posedge clk);
    if (r_i) begin
      ea = 4'hF; es = SB; k = 0; mvalid = 0; merr = 0; mq = 0; mr = 0;
    end else begin
      idx = (k / R) % 4;
      ea  = mvalid ? ~(4'b0001 << idx) : 4'hF;
      es  = model_seg(idx);
      if (f) begin
        mq = q; mr = rr; mvalid = 1; merr = (q == 15 && rr == 15);
      end
      k++;
    end
    #1;
    chk("model_an", an, ea);
    chk("model_seg", seg, es);
    chk("model_valid", valid, mvalid);
    chk("model_err", err, merr);
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  initial begin
    vecs[0] = '{2,  1,  {SB, S2, SB, S1}, 1'b0};
    vecs[1] = '{15, 0,  {S1, S5, SB, S0}, 1'b0};
    vecs[2] = '{15, 15, {SE, SR, SR, SB}, 1'b1};
    vecs[3] = '{3,  0,  {SB, S3, SB, S0}, 1'b0};
    vecs[4] = '{12, 9,  {S1, S2, SB, S9}, 1'b0};
    vecs[5] = '{0,  0,  {SB, S0, SB, S0}, 1'b0};
    vecs[6] = '{10, 14, {S1, S0, S1, S4}, 1'b0};

    rst = 1'b1; bus.finish = 1'b0; bus.cociente = '0; bus.resto = '0;
    k = 0; mq = 0; mr = 0; mvalid = 0; merr = 0;

    // Reset, then a dark idle display
    step(1, 0, 0, 0);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, SB);
    for (int c = 0; c < 20; c++) begin
      step(0, 0, 0, 0);
      chk("idle_an", an, 4'hF);
      chk("idle_valid", valid, 0);
    end

    // Table: capture each result and scan all four digits
    for (int i = 0; i < 7; i++) begin
      bit seen[4];
      int nseen;
      int di;
      for (int j = 0; j < 4; j++) seen[j] = 0;
      step(0, 1, vecs[i].q, vecs[i].r);
      chk("tbl_valid", valid, 1);
      for (int c = 0; c < 4 * R + 1; c++) begin
        step(0, 0, 0, 0);
        di = an_idx(an);
        if (di < 0) chk("tbl_onehot", an, 4'b1110);
        else begin
          seen[di] = 1;
          chk("tbl_seg", seg, vecs[i].d[di]);
        end
        chk("tbl_err", err, vecs[i].e);
      end
      nseen = 0;
      for (int j = 0; j < 4; j++) nseen += seen[j];
      chk("tbl_all_digits", nseen, 4);
    end

    // Two finishes two cycles apart; final display must show 7
    step(0, 1, 4, 0);
    step(0, 0, 0, 0);
    step(0, 1, 7, 0);
    for (int c = 0; c < 4 * R + 1; c++) begin
      step(0, 0, 0, 0);
      if (an == 4'b1011) chk("b2b_final7", seg, S7);
    end

    // Reset coincident with finish while digit 2 is lit
    begin
      int guard;
      step(0, 1, 9, 3);
      guard = 0;
      while (an != 4'b1011 && guard < 40) begin
        step(0, 0, 0, 0);
        guard++;
      end
      chk("rst_wait_digit2", an, 4'b1011);
      step(1, 1, 5, 5);
      chk("rst_an", an, 4'hF);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      for (int c = 0; c < 10; c++) step(0, 0, 0, 0);
      chk("rst_no_capture", valid, 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      bit r_i, f;
      int q, rr;
      r_i = ($urandom_range(0, 99) == 0);
      f   = ($urandom_range(0, 4) == 0);
      q   = $urandom_range(0, 15);
      rr  = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin q = 15; rr = 15; end
      step(r_i, f, q, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
